// File: rtl/quadra_arb.sv
// quadra_arb: N_REQ-way arbiter in front of one fixed-latency quadratic datapath.
// Operands are accepted one per cycle. They are issued to the datapath with a
// tag carrying the requester index. Results return in order and are routed back
// with a one-hot valid.
// Build option: define QUADRA_ARB_RR_EN for round-robin arbitration. When it is
// undefined, arbitration is fixed priority and the lowest index wins.
module quadra_arb #(
    parameter int N_REQ = 4,
    parameter int LAT   = 3,
    parameter int X_W   = 24,
    parameter int Y_W   = 24
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N_REQ*X_W-1:0]     req_x,
    input  logic [N_REQ-1:0]         req_dv,
    output logic [N_REQ-1:0]         req_rdy,
    output logic [X_W-1:0]           dp_x,
    output logic                     dp_x_dv,
    input  logic [Y_W-1:0]           dp_y,
    input  logic                     dp_y_dv,
    output logic [Y_W-1:0]           rsp_y,
    output logic [N_REQ-1:0]         rsp_dv,
    output logic [$clog2(LAT+2)-1:0] occ,
    output logic                     err
);

    localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int CNT_W = $clog2(LAT + 2);

    typedef enum logic {
        ST_DRAIN = 1'b0,
        ST_RUN   = 1'b1
    } state_t;

    // One tag per issued operand. It travels alongside the datapath.
    typedef struct packed {
        logic             valid;
        logic [IDX_W-1:0] idx;
    } tag_t;

    function automatic logic [N_REQ-1:0] onehot(input logic [IDX_W-1:0] idx);
        logic [N_REQ-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

    state_t           state_q, state_d;
    logic [CNT_W-1:0] drain_q, drain_d;
    logic             run_en;

    logic             gnt_vld;
    logic [IDX_W-1:0] gnt_idx;
    logic [IDX_W-1:0] cand;
    logic             xfer;
    logic [X_W-1:0]   sel_x;

    tag_t             tag_q [0:LAT];
    tag_t             cmp_tag;
    logic             rsp_hit;
    logic             proto_err;

`ifdef QUADRA_ARB_RR_EN
    logic [IDX_W-1:0] rr_ptr_q;
`endif

    // ------------------------------------------------------------------
    // Control FSM. Reset parks it in DRAIN with a full count. It moves to
    // RUN after LAT+1 quiet cycles, so every pre-reset result has gone by.
    // ------------------------------------------------------------------

    // State and drain-counter registers.
    always_ff @(posedge clk) begin
        // NOTE: sequential state always uses <= so every register samples pre-edge values.
        if (rst) begin
            state_q <= ST_DRAIN;
            drain_q <= CNT_W'(LAT + 1);
        end else begin
            state_q <= state_d;
            drain_q <= drain_d;
        end
    end

    // Next-state logic: count down in DRAIN, then stay in RUN until reset.
    always_comb begin
        // NOTE: every always_comb output gets a default first, so no path can infer a latch.
        state_d = state_q;
        drain_d = drain_q;
        case (state_q)
            ST_DRAIN: begin
                if (drain_q <= CNT_W'(1)) begin
                    state_d = ST_RUN;
                    drain_d = '0;
                end else begin
                    drain_d = drain_q - CNT_W'(1);
                end
            end
            ST_RUN:  state_d = ST_RUN;
            default: state_d = ST_DRAIN;
        endcase
    end

    // rst is synchronous. Gating with it here keeps req_rdy low in the same
    // cycle that reset is asserted, before the state register has moved.
    assign run_en = (state_q == ST_RUN) && !rst;

    // ------------------------------------------------------------------
    // Arbitration
    // ------------------------------------------------------------------

    // Search the requesters in priority order and take the first one whose
    // req_dv is high.
    always_comb begin
        gnt_vld = 1'b0;
        gnt_idx = '0;
        cand    = '0;
        for (int i = 0; i < N_REQ; i++) begin
`ifdef QUADRA_ARB_RR_EN
            cand = IDX_W'((int'(rr_ptr_q) + 1 + i) % N_REQ);
`else
            cand = IDX_W'(i);
`endif
            if (!gnt_vld && req_dv[cand]) begin
                gnt_vld = 1'b1;
                gnt_idx = cand;
            end
        end
        if (!run_en) begin
            gnt_vld = 1'b0;
        end
    end

    // Drive the single ready bit of the granted requester.
    always_comb begin
        req_rdy = '0;
        if (gnt_vld) begin
            req_rdy = onehot(gnt_idx);
        end
    end

    // A grant is only ever given to a requester with req_dv high, so every
    // grant is a transfer.
    assign xfer  = gnt_vld;
    assign sel_x = req_x[int'(gnt_idx)*X_W +: X_W];

`ifdef QUADRA_ARB_RR_EN
    // Round-robin pointer: remembers the last granted index. It moves only
    // on a transfer.
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr_q <= IDX_W'(N_REQ - 1);
        end else if (xfer) begin
            rr_ptr_q <= gnt_idx;
        end
    end
`endif

    // ------------------------------------------------------------------
    // Issue side
    // ------------------------------------------------------------------

    // Operand register toward the datapath. dp_x holds its value between
    // transfers.
    always_ff @(posedge clk) begin
        if (rst) begin
            dp_x    <= '0;
            dp_x_dv <= 1'b0;
        end else begin
            dp_x_dv <= xfer;
            if (xfer) begin
                dp_x <= sel_x;
            end
        end
    end

    // Tag shift register. Stage 0 is aligned with dp_x_dv. Stage LAT is
    // aligned with the cycle in which dp_y_dv is due.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: the whole tag array is reset, because a surviving valid bit would produce a phantom response after reset.
            for (int k = 0; k <= LAT; k++) begin
                tag_q[k] <= '0;
            end
        end else begin
            tag_q[0] <= tag_t'{valid: xfer, idx: gnt_idx};
            for (int k = 1; k <= LAT; k++) begin
                tag_q[k] <= tag_q[k-1];
            end
        end
    end

    // ------------------------------------------------------------------
    // Return side
    // ------------------------------------------------------------------

    assign cmp_tag   = tag_q[LAT];
    assign rsp_hit   = run_en && dp_y_dv && cmp_tag.valid;
    assign proto_err = run_en && (dp_y_dv != cmp_tag.valid);

    // Response register. The result is routed to the tagged requester.
    // rsp_y holds its value between results.
    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_y  <= '0;
            rsp_dv <= '0;
        end else begin
            rsp_dv <= '0;
            if (rsp_hit) begin
                rsp_y  <= dp_y;
                rsp_dv <= onehot(cmp_tag.idx);
            end
        end
    end

    // Sticky mismatch flag. It is set when a result arrives without a tag,
    // or a tag arrives without a result. Only reset clears it.
    always_ff @(posedge clk) begin
        if (rst) begin
            err <= 1'b0;
        end else if (proto_err) begin
            err <= 1'b1;
        end
    end

    // In-flight counter. It goes up on issue and down when a valid tag leaves
    // the compare stage, whether or not the result matched.
    always_ff @(posedge clk) begin
        if (rst) begin
            occ <= '0;
        end else begin
            case ({xfer, cmp_tag.valid})
                2'b10:   occ <= occ + CNT_W'(1);
                2'b01:   occ <= occ - CNT_W'(1);
                default: occ <= occ;
            endcase
        end
    end

endmodule
